// File: rtl/h80cpu_uart_rx_pkg.sv
// Shared h80 bus definitions for the UART receiver: bus command encodings,
// register map, status bit positions and the receiver FSM state type.
package h80cpu_uart_rx_pkg;

   // Bus command encodings
   localparam logic [2:0] bus_cmd_read_b  = 3'b001;
   localparam logic [2:0] bus_cmd_write_b = 3'b010;

   // Register map
   localparam logic [15:0] RX_DATA   = 16'h0000;
   localparam logic [15:0] RX_STATUS = 16'h0001;

   // Status register bit positions
   localparam int STAT_AVAIL_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVR_BIT   = 2;
   localparam int STAT_FERR_BIT  = 3;

   // Serial receiver states
   typedef enum logic [1:0] {
      RXS_IDLE  = 2'b00,
      RXS_START = 2'b01,
      RXS_DATA  = 2'b10,
      RXS_STOP  = 2'b11
   } rx_state_t;

   // Assemble the low nibble of the status register
   function automatic logic [3:0] pack_status(input logic avail, input logic full,
                                              input logic ovr, input logic ferr);
      logic [3:0] st;
      st = 4'h0;
      st[STAT_AVAIL_BIT] = avail;
      st[STAT_FULL_BIT]  = full;
      st[STAT_OVR_BIT]   = ovr;
      st[STAT_FERR_BIT]  = ferr;
      return st;
   endfunction

endpackage

// File: rtl/h80cpu_uart_rx_core.sv
// h80_uart_rx_core: 8N1 serial deserialiser. Synchronises the line, detects
// the start bit, samples 8 data bits LSB first at mid-bit and checks the stop
// bit. Emits a one-cycle valid pulse with the byte, or a one-cycle ferr pulse.
module h80_uart_rx_core
   import h80cpu_uart_rx_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 230400
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       uart_rxp,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV + 1);

   logic            rx_meta_r;
   logic            rx_sync_r;
   logic            rx_prev_r;
   logic [2:0]      warm_r;
   logic            fall_s;

   rx_state_t       state_r;
   rx_state_t       state_nx_s;
   logic [CNT_W-1:0] baud_cnt_r;
   logic [CNT_W-1:0] baud_cnt_nx_s;
   logic [2:0]      bit_cnt_r;
   logic [2:0]      bit_cnt_nx_s;
   logic [7:0]      shift_r;
   logic [7:0]      shift_nx_s;
   logic            stop_wait_r;
   logic            stop_wait_nx_s;
   logic            valid_nx_s;
   logic            ferr_nx_s;

   logic [7:0]      byte_r;
   logic            valid_r;
   logic            ferr_r;

   // Two-flop synchroniser, edge history, and warm-up mask so that the
   // reset value of the flops never counts as a line level after reset
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
         warm_r    <= 3'b000;
      end else begin
         rx_meta_r <= uart_rxp;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         warm_r    <= {warm_r[1:0], 1'b1};
      end
   end

   assign fall_s = warm_r[2] & rx_prev_r & ~rx_sync_r;

   // Receiver state and counters
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_r     <= RXS_IDLE;
         baud_cnt_r  <= '0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         stop_wait_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         baud_cnt_r  <= baud_cnt_nx_s;
         bit_cnt_r   <= bit_cnt_nx_s;
         shift_r     <= shift_nx_s;
         stop_wait_r <= stop_wait_nx_s;
      end
   end

   // Next-state logic: sample points fall HALF sysclks after the start edge
   // and then every DIV sysclks
   always_comb begin
      state_nx_s     = state_r;
      baud_cnt_nx_s  = baud_cnt_r + CNT_W'(1);
      bit_cnt_nx_s   = bit_cnt_r;
      shift_nx_s     = shift_r;
      stop_wait_nx_s = stop_wait_r;
      valid_nx_s     = 1'b0;
      ferr_nx_s      = 1'b0;
      case (state_r)
         RXS_IDLE: begin
            baud_cnt_nx_s  = '0;
            bit_cnt_nx_s   = 3'd0;
            stop_wait_nx_s = 1'b0;
            if (fall_s) begin
               state_nx_s = RXS_START;
            end else begin
               state_nx_s = RXS_IDLE;
            end
         end
         RXS_START: begin
            if (baud_cnt_r == CNT_W'(HALF - 1)) begin
               baud_cnt_nx_s = '0;
               bit_cnt_nx_s  = 3'd0;
               if (!rx_sync_r) begin
                  state_nx_s = RXS_DATA;
               end else begin
                  state_nx_s = RXS_IDLE;
               end
            end else begin
               state_nx_s = RXS_START;
            end
         end
         RXS_DATA: begin
            if (baud_cnt_r == CNT_W'(DIV - 1)) begin
               baud_cnt_nx_s = '0;
               shift_nx_s    = {rx_sync_r, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_nx_s     = RXS_STOP;
                  bit_cnt_nx_s   = 3'd0;
                  stop_wait_nx_s = 1'b0;
               end else begin
                  bit_cnt_nx_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_nx_s = RXS_DATA;
            end
         end
         RXS_STOP: begin
            if (stop_wait_r) begin
               baud_cnt_nx_s = '0;
               if (rx_sync_r) begin
                  state_nx_s     = RXS_IDLE;
                  stop_wait_nx_s = 1'b0;
               end else begin
                  state_nx_s = RXS_STOP;
               end
            end else if (baud_cnt_r == CNT_W'(DIV - 1)) begin
               baud_cnt_nx_s = '0;
               if (rx_sync_r) begin
                  valid_nx_s = 1'b1;
                  state_nx_s = RXS_IDLE;
               end else begin
                  ferr_nx_s      = 1'b1;
                  stop_wait_nx_s = 1'b1;
               end
            end else begin
               state_nx_s = RXS_STOP;
            end
         end
         default: begin
            state_nx_s     = RXS_IDLE;
            baud_cnt_nx_s  = '0;
            bit_cnt_nx_s   = 3'd0;
            stop_wait_nx_s = 1'b0;
         end
      endcase
   end

   // Registered result pulses
   always_ff @(posedge sysclk) begin
      if (reset) begin
         byte_r  <= 8'h00;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         valid_r <= valid_nx_s;
         ferr_r  <= ferr_nx_s;
         if (valid_nx_s) begin
            byte_r <= shift_r;
         end
      end
   end

   assign rx_byte  = byte_r;
   assign rx_valid = valid_r;
   assign rx_ferr  = ferr_r;

endmodule

// File: rtl/h80cpu_uart_rx.sv
// h80cpu_uart_rx: UART receiver peripheral on the h80 CPU bus. The
// deserialiser feeds a receive buffer read through RX_DATA (stalling the
// bus while empty) with error flags in RX_STATUS.
// Build option: H80CPU_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO;
// without it a single-byte holding register is used.
module h80cpu_uart_rx
   import h80cpu_uart_rx_pkg::*;
#(
   parameter int BUS_ADDR_WIDTH = 16,
   parameter int BUS_CMD_WIDTH  = 3,
   parameter int BUS_DATA_WIDTH = 16,
   parameter int CLK_FREQ       = 50000000,
   parameter int BAUD           = 230400,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                      sysclk,
   input  logic                      reset,
   input  logic                      clk,
   input  logic                      ce_n,
   input  logic [BUS_ADDR_WIDTH-1:0] addr,
   input  logic [BUS_CMD_WIDTH-1:0]  cmd,
   inout  wire  [BUS_DATA_WIDTH-1:0] data,
   output logic                      wait_n,
   input  logic                      uart_rxp
);

   logic [7:0] rx_byte_s;
   logic       rx_valid_s;
   logic       rx_ferr_s;

   logic       prev_clk_r;
   logic       clk_rise_s;
   logic       rd_cmd_s;
   logic       data_acc_s;
   logic       stat_acc_s;

   logic       empty_s;
   logic       full_s;
   logic [7:0] head_s;
   logic       pop_s;
   logic       push_s;
   logic       ovr_set_s;

   logic       ovr_r;
   logic       ferr_r;

   logic                      drive_s;
   logic [BUS_DATA_WIDTH-1:0] rd_data_s;

   h80_uart_rx_core #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_core (
      .sysclk   (sysclk),
      .reset    (reset),
      .uart_rxp (uart_rxp),
      .rx_byte  (rx_byte_s),
      .rx_valid (rx_valid_s),
      .rx_ferr  (rx_ferr_s)
   );

   // Bus clock history for rising-edge detection in the sysclk domain
   always_ff @(posedge sysclk) begin
      if (reset) begin
         prev_clk_r <= 1'b0;
      end else begin
         prev_clk_r <= clk;
      end
   end

   assign clk_rise_s = ~prev_clk_r & clk;
   assign rd_cmd_s   = ~ce_n & (cmd == BUS_CMD_WIDTH'(bus_cmd_read_b));
   assign data_acc_s = rd_cmd_s & (addr == BUS_ADDR_WIDTH'(RX_DATA));
   assign stat_acc_s = rd_cmd_s & (addr == BUS_ADDR_WIDTH'(RX_STATUS));

   // A pop frees a slot in the same cycle, so a push into a full buffer that
   // coincides with a pop is accepted rather than counted as an overrun
   assign pop_s     = clk_rise_s & data_acc_s & ~empty_s;
   assign push_s    = rx_valid_s & (~full_s | pop_s);
   assign ovr_set_s = rx_valid_s & full_s & ~pop_s;

`ifdef H80CPU_UART_RX_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   assign empty_s = (count_r == CNT_W'(0));
   assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
   assign head_s  = mem_r[rd_ptr_r];

   // FIFO storage; contents are only meaningful below count_r
   always_ff @(posedge sysclk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= rx_byte_s;
      end
   end

   // FIFO pointers (natural power-of-two wrap) and occupancy
   always_ff @(posedge sysclk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
`else
   logic [7:0] hold_r;
   logic       hold_vld_r;

   assign empty_s = ~hold_vld_r;
   assign full_s  = hold_vld_r;
   assign head_s  = hold_r;

   // Single-byte holding register
   always_ff @(posedge sysclk) begin
      if (reset) begin
         hold_r     <= 8'h00;
         hold_vld_r <= 1'b0;
      end else begin
         if (push_s) begin
            hold_r     <= rx_byte_s;
            hold_vld_r <= 1'b1;
         end else if (pop_s) begin
            hold_vld_r <= 1'b0;
         end
      end
   end
`endif

   // Sticky error flags; a new error in the clearing cycle keeps the flag set
   always_ff @(posedge sysclk) begin
      if (reset) begin
         ovr_r  <= 1'b0;
         ferr_r <= 1'b0;
      end else begin
         if (ovr_set_s) begin
            ovr_r <= 1'b1;
         end else if (clk_rise_s & stat_acc_s) begin
            ovr_r <= 1'b0;
         end
         if (rx_ferr_s) begin
            ferr_r <= 1'b1;
         end else if (clk_rise_s & stat_acc_s) begin
            ferr_r <= 1'b0;
         end
      end
   end

   // Read data mux and bus drive enable
   always_comb begin
      rd_data_s = '0;
      drive_s   = 1'b0;
      if (data_acc_s & ~empty_s) begin
         rd_data_s = {{(BUS_DATA_WIDTH - 8){1'b0}}, head_s};
         drive_s   = 1'b1;
      end else if (stat_acc_s) begin
         rd_data_s = {{(BUS_DATA_WIDTH - 4){1'b0}},
                      pack_status(~empty_s, full_s, ovr_r, ferr_r)};
         drive_s   = 1'b1;
      end else begin
         rd_data_s = '0;
         drive_s   = 1'b0;
      end
   end

   assign data   = drive_s ? rd_data_s : {BUS_DATA_WIDTH{1'bz}};
   assign wait_n = ~(data_acc_s & empty_s);

endmodule
